// File: rtl/div_issue_ctrl_pkg.sv
// Shared definitions for the DIV issue controller: default widths, divider
// latency and the controller state encoding.
package div_issue_ctrl_pkg;

  localparam int unsigned DIV_DATA_W  = 32;
  localparam int unsigned DIV_LAT_DEF = 16;

  typedef enum logic [2:0] {
    DIV_ST_IDLE  = 3'd0,
    DIV_ST_ISSUE = 3'd1,
    DIV_ST_WAIT  = 3'd2,
    DIV_ST_WRITE = 3'd3,
    DIV_ST_DRAIN = 3'd4
  } div_state_e;

endpackage

// File: rtl/div_issue_ctrl_if.sv
// Launch/return bus between the DIV issue controller (master) and the
// pipelined divider (slave).
interface div_issue_ctrl_if #(
  parameter int unsigned DATA_W = 32
);
  logic              div_ce;
  logic              div_signed;
  logic [DATA_W-1:0] div_dividend;
  logic [DATA_W-1:0] div_divisor;
  logic              div_done;
  logic [DATA_W-1:0] div_quotient;
  logic [DATA_W-1:0] div_remainder;

  modport master (
    output div_ce, div_signed, div_dividend, div_divisor,
    input  div_done, div_quotient, div_remainder
  );

  modport slave (
    input  div_ce, div_signed, div_dividend, div_divisor,
    output div_done, div_quotient, div_remainder
  );
endinterface

// File: rtl/div_issue_ctrl_hilo_reg.sv
// Architectural HI/LO storage. A divide capture writes both halves and wins
// over MTHI/MTLO in the same cycle.
module hilo_reg #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cap_en,
  input  logic [DATA_W-1:0] i_cap_hi,
  input  logic [DATA_W-1:0] i_cap_lo,
  input  logic              i_mthi_en,
  input  logic              i_mtlo_en,
  input  logic [DATA_W-1:0] i_mt_data,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo
);

  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (i_cap_en) begin
      r_hi <= i_cap_hi;
      r_lo <= i_cap_lo;
    end else begin
      if (i_mthi_en) r_hi <= i_mt_data;
      if (i_mtlo_en) r_lo <= i_mt_data;
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/div_issue_ctrl.sv
// EX-stage initiator for the pipelined divider: launches a divide, stalls the
// pipeline until the result returns, and owns HI/LO.
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W    = DIV_DATA_W,
  parameter int unsigned DIV_LAT   = DIV_LAT_DEF,
  parameter int unsigned TMO_SLACK = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 ex_stall,
  input  logic                 ex_valid,
  input  logic                 ex_is_div,
  input  logic                 ex_signed,
  input  logic                 ex_mthi,
  input  logic                 ex_mtlo,
  input  logic [DATA_W-1:0]    ex_rs,
  input  logic [DATA_W-1:0]    ex_rt,
  div_issue_ctrl_if.master     div_if,
  output logic                 stall_req,
  output logic [DATA_W-1:0]    hi_out,
  output logic [DATA_W-1:0]    lo_out,
  output logic                 div_err
);

  localparam int unsigned LIMIT_I = DIV_LAT + TMO_SLACK;
  localparam int unsigned CNT_W   = $clog2(LIMIT_I + 2);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(LIMIT_I);

  div_state_e        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ce;
  logic              r_signed;
  logic [DATA_W-1:0] r_dividend;
  logic [DATA_W-1:0] r_divisor;
  logic              r_err;

  logic w_launch;
  logic w_mt_ok;
  logic w_cap;
  logic w_stall;

  assign w_launch = ex_valid & ex_is_div & (ex_rt != '0) & ~flush;
  assign w_mt_ok  = (r_state == DIV_ST_IDLE) & ex_valid & ~flush & ~ex_stall;
  assign w_cap    = (r_state == DIV_ST_WAIT) & div_if.div_done & ~flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= DIV_ST_IDLE;
      r_cnt      <= '0;
      r_ce       <= 1'b0;
      r_signed   <= 1'b0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_ce <= 1'b0;
      unique case (r_state)
        DIV_ST_IDLE: begin
          if (w_launch) begin
            r_state    <= DIV_ST_ISSUE;
            r_ce       <= 1'b1;
            r_signed   <= ex_signed;
            r_dividend <= ex_rs;
            r_divisor  <= ex_rt;
          end
        end
        DIV_ST_ISSUE: begin
          r_cnt   <= '0;
          r_state <= flush ? DIV_ST_DRAIN : DIV_ST_WAIT;
        end
        DIV_ST_WAIT: begin
          if (flush) begin
            r_state <= div_if.div_done ? DIV_ST_IDLE : DIV_ST_DRAIN;
            r_cnt   <= r_cnt + CNT_W'(1);
          end else if (div_if.div_done) begin
            r_state <= DIV_ST_WRITE;
          end else if (r_cnt == LIMIT) begin
            r_err   <= 1'b1;
            r_state <= DIV_ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DIV_ST_WRITE: begin
          if (flush || !ex_stall) r_state <= DIV_ST_IDLE;
        end
        DIV_ST_DRAIN: begin
          // Counter keeps running from launch so the drain shares the WAIT deadline.
          if (div_if.div_done || r_cnt >= LIMIT) r_state <= DIV_ST_IDLE;
          else                                   r_cnt   <= r_cnt + CNT_W'(1);
        end
        default: r_state <= DIV_ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_stall = 1'b0;
    unique case (r_state)
      DIV_ST_IDLE:                w_stall = w_launch;
      DIV_ST_ISSUE, DIV_ST_WAIT:  w_stall = 1'b1;
      DIV_ST_WRITE:               w_stall = 1'b0;
      DIV_ST_DRAIN:               w_stall = ex_valid & (ex_is_div | ex_mthi | ex_mtlo);
      default:                    w_stall = 1'b0;
    endcase
  end

  assign stall_req           = reset & w_stall;
  assign div_if.div_ce       = r_ce;
  assign div_if.div_signed   = r_signed;
  assign div_if.div_dividend = r_dividend;
  assign div_if.div_divisor  = r_divisor;
  assign div_err             = r_err;

  hilo_reg #(.DATA_W(DATA_W)) u_hilo (
    .i_clk     (clk),
    .i_rst_n   (reset),
    .i_cap_en  (w_cap),
    .i_cap_hi  (div_if.div_remainder),
    .i_cap_lo  (div_if.div_quotient),
    .i_mthi_en (w_mt_ok & ex_mthi),
    .i_mtlo_en (w_mt_ok & ex_mtlo),
    .i_mt_data (ex_rs),
    .o_hi      (hi_out),
    .o_lo      (lo_out)
  );

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a fixed-latency divider model and a
// scoreboard of expected HI/LO results.
module tb_div_issue_ctrl;

  localparam int unsigned DIV_LAT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush, ex_stall, ex_valid, ex_is_div, ex_signed, ex_mthi, ex_mtlo;
  logic [31:0] ex_rs, ex_rt;
  logic        stall_req, div_err;
  logic [31:0] hi_out, lo_out;

  div_issue_ctrl_if #(.DATA_W(32)) dv ();

  div_issue_ctrl #(.DATA_W(32), .DIV_LAT(DIV_LAT), .TMO_SLACK(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .ex_stall  (ex_stall),
    .ex_valid  (ex_valid),
    .ex_is_div (ex_is_div),
    .ex_signed (ex_signed),
    .ex_mthi   (ex_mthi),
    .ex_mtlo   (ex_mtlo),
    .ex_rs     (ex_rs),
    .ex_rt     (ex_rt),
    .div_if    (dv.master),
    .stall_req (stall_req),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .div_err   (div_err)
  );

  always #5 clk = ~clk;

  // Divider model: result appears DIV_LAT cycles after the cycle carrying div_ce.
  logic        m_done = 1'b0;
  logic [31:0] m_q = '0, m_r = '0, m_rq = '0, m_rr = '0;
  logic        m_pend = 1'b0;
  logic        model_dead = 1'b0;
  int          m_cnt = 0;
  int unsigned ce_count = 0;

  assign dv.div_done      = m_done;
  assign dv.div_quotient  = m_q;
  assign dv.div_remainder = m_r;

  always @(posedge clk) begin
    m_done <= 1'b0;
    if (dv.div_ce === 1'b1) begin
      ce_count <= ce_count + 1;
      m_cnt    <= DIV_LAT - 1;
      m_pend   <= !model_dead;
      if (dv.div_signed) begin
        m_rq <= $signed(dv.div_dividend) / $signed(dv.div_divisor);
        m_rr <= $signed(dv.div_dividend) % $signed(dv.div_divisor);
      end else begin
        m_rq <= dv.div_dividend / dv.div_divisor;
        m_rr <= dv.div_dividend % dv.div_divisor;
      end
    end else if (m_pend) begin
      if (m_cnt == 1) begin
        m_done <= 1'b1;
        m_q    <= m_rq;
        m_r    <= m_rr;
        m_pend <= 1'b0;
      end
      m_cnt <= m_cnt - 1;
    end
  end

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] sb_q[$];
  logic [31:0] model_hi = '0, model_lo = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present_div(input logic [31:0] rs, input logic [31:0] rt, input logic sgn);
    ex_valid = 1'b1; ex_is_div = 1'b1; ex_mthi = 1'b0; ex_mtlo = 1'b0;
    ex_signed = sgn; ex_rs = rs; ex_rt = rt;
  endtask

  task automatic drop_ex();
    ex_valid = 1'b0; ex_is_div = 1'b0; ex_mthi = 1'b0; ex_mtlo = 1'b0;
  endtask

  // Starts in the cycle the DIV is presented (cycle 0); returns in WRITE (cycle 18).
  task automatic run_div(input logic [31:0] rs, input logic [31:0] rt, input logic sgn,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input logic mtlo_mid, input logic [31:0] mtv);
    int unsigned ce0;
    logic [63:0] e;
    ce0 = ce_count;
    present_div(rs, rt, sgn);
    sb_q.push_back({ehi, elo});
    #1 chk("stall_c0", 32'(stall_req), 32'd1);
    for (int c = 1; c <= 17; c++) begin
      tick();
      if (mtlo_mid && c == 5) begin
        ex_is_div = 1'b0; ex_mtlo = 1'b1; ex_rs = mtv;
      end
      #1;
      chk("stall_busy", 32'(stall_req), 32'd1);
      if (c == 1) begin
        chk("ce_issue", 32'(dv.div_ce), 32'd1);
        chk("div_signed", 32'(dv.div_signed), 32'(sgn));
        chk("div_dividend", dv.div_dividend, rs);
        chk("div_divisor", dv.div_divisor, rt);
      end
      if (c == 2) chk("ce_wait", 32'(dv.div_ce), 32'd0);
    end
    tick(); #1;
    chk("stall_write", 32'(stall_req), 32'd0);
    e = sb_q.pop_front();
    model_hi = e[63:32];
    model_lo = e[31:0];
    chk("hi_div", hi_out, model_hi);
    chk("lo_div", lo_out, model_lo);
    chk("ce_per_div", 32'(ce_count - ce0), 32'd1);
  endtask

  initial begin
    int unsigned ce0;
    reset = 1'b0; flush = 1'b0; ex_stall = 1'b0; ex_signed = 1'b0;
    ex_rs = '0; ex_rt = '0;
    drop_ex();
    #2;
    chk("rst_ce", 32'(dv.div_ce), 32'd0);
    chk("rst_signed", 32'(dv.div_signed), 32'd0);
    chk("rst_dividend", dv.div_dividend, 32'd0);
    chk("rst_divisor", dv.div_divisor, 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    chk("rst_err", 32'(div_err), 32'd0);
    chk("rst_hi", hi_out, 32'd0);
    chk("rst_lo", lo_out, 32'd0);
    tick(); reset = 1'b1;
    tick(); tick();

    // DIVU 100/7, then hold WRITE with ex_stall: no relaunch.
    run_div(32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 1'b0, '0);
    ce0 = ce_count;
    ex_stall = 1'b1;
    tick(); #1;
    chk("write_hold_stall", 32'(stall_req), 32'd0);
    chk("write_hold_ce", 32'(dv.div_ce), 32'd0);
    tick();
    ex_stall = 1'b0;
    tick(); drop_ex(); #1;
    chk("write_hold_no_relaunch", 32'(ce_count - ce0), 32'd0);
    chk("write_hold_lo", lo_out, model_lo);
    tick();

    // Signed -7/2 followed back-to-back by 8/2.
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, '0);
    tick();
    run_div(32'd8, 32'd2, 1'b1, 32'd0, 32'd4, 1'b0, '0);
    tick(); drop_ex(); tick();

    // MTHI in IDLE takes effect at the next edge; blocked while ex_stall.
    ex_valid = 1'b1; ex_mthi = 1'b1; ex_rs = 32'hAAAA_0000; #1;
    chk("mthi_before_edge", hi_out, model_hi);
    tick(); model_hi = 32'hAAAA_0000; #1;
    chk("mthi_after_edge", hi_out, model_hi);
    ex_rs = 32'h5555_5555; ex_stall = 1'b1;
    tick(); #1;
    chk("mthi_stalled", hi_out, model_hi);
    ex_stall = 1'b0; ex_rs = 32'h1234;
    tick(); ex_mthi = 1'b0; ex_mtlo = 1'b1; model_hi = 32'h1234;
    tick(); drop_ex(); model_lo = 32'h1234; #1;
    chk("mt_setup_hi", hi_out, model_hi);
    chk("mt_setup_lo", lo_out, model_lo);

    // Divide by zero: no launch, no stall, HI/LO untouched.
    ce0 = ce_count;
    present_div(32'd5, 32'd0, 1'b1); #1;
    chk("div0_stall", 32'(stall_req), 32'd0);
    tick(); #1;
    chk("div0_stall_next", 32'(stall_req), 32'd0);
    tick(); drop_ex(); #1;
    chk("div0_no_ce", 32'(ce_count - ce0), 32'd0);
    chk("div0_hi", hi_out, model_hi);
    chk("div0_lo", lo_out, model_lo);
    tick();

    // Flush in WAIT cycle 5; DIVU 9/3 presented in cycle 10 waits out the drain.
    ce0 = ce_count;
    present_div(32'd50, 32'd5, 1'b0); #1;
    chk("fl_stall_c0", 32'(stall_req), 32'd1);
    for (int c = 1; c <= 4; c++) tick();
    tick(); flush = 1'b1; drop_ex(); #1;
    chk("fl_stall_c5", 32'(stall_req), 32'd1);
    tick(); flush = 1'b0; #1;
    chk("drain_idle_stall", 32'(stall_req), 32'd0);
    for (int c = 7; c <= 10; c++) tick();
    present_div(32'd9, 32'd3, 1'b0); #1;
    chk("drain_hold_c10", 32'(stall_req), 32'd1);
    for (int c = 11; c <= 17; c++) begin
      tick(); #1;
      chk("drain_hold", 32'(stall_req), 32'd1);
    end
    tick();
    chk("drain_hi", hi_out, model_hi);
    chk("drain_lo", lo_out, model_lo);
    chk("drain_one_ce", 32'(ce_count - ce0), 32'd1);
    run_div(32'd9, 32'd3, 1'b0, 32'd0, 32'd3, 1'b0, '0);
    tick(); drop_ex(); tick();

    // MTLO arrives during WAIT and lands after the divide's WRITE.
    run_div(32'd20, 32'd6, 1'b0, 32'd2, 32'd3, 1'b1, 32'hCAFE_BABE);
    tick(); #1;
    chk("mtlo_held_lo", lo_out, 32'd3);
    chk("mtlo_idle_stall", 32'(stall_req), 32'd0);
    tick(); drop_ex(); model_lo = 32'hCAFE_BABE; #1;
    chk("mtlo_written", lo_out, model_lo);
    chk("mtlo_hi_kept", hi_out, model_hi);
    tick();

    // Divider never answers: div_err after WAIT counter reaches 20.
    model_dead = 1'b1;
    ce0 = ce_count;
    present_div(32'd7, 32'd1, 1'b0);
    for (int c = 1; c <= 22; c++) tick();
    #1;
    chk("tmo_err_c22", 32'(div_err), 32'd0);
    chk("tmo_stall_c22", 32'(stall_req), 32'd1);
    tick(); drop_ex(); #1;
    chk("tmo_err_c23", 32'(div_err), 32'd1);
    chk("tmo_stall_c23", 32'(stall_req), 32'd0);
    chk("tmo_hi", hi_out, model_hi);
    chk("tmo_lo", lo_out, model_lo);
    tick(); #1;
    chk("tmo_err_sticky", 32'(div_err), 32'd1);
    chk("tmo_one_ce", 32'(ce_count - ce0), 32'd1);
    model_dead = 1'b0;

    // Reset mid-WAIT clears everything at once; the late divider result is ignored.
    present_div(32'd100, 32'd7, 1'b1);
    for (int c = 1; c <= 6; c++) tick();
    reset = 1'b0; #1;
    chk("amid_ce", 32'(dv.div_ce), 32'd0);
    chk("amid_signed", 32'(dv.div_signed), 32'd0);
    chk("amid_dividend", dv.div_dividend, 32'd0);
    chk("amid_divisor", dv.div_divisor, 32'd0);
    chk("amid_stall", 32'(stall_req), 32'd0);
    chk("amid_err", 32'(div_err), 32'd0);
    chk("amid_hi", hi_out, 32'd0);
    chk("amid_lo", lo_out, 32'd0);
    drop_ex();
    tick(); reset = 1'b1;
    ce0 = ce_count;
    for (int c = 0; c < 14; c++) tick();
    chk("post_rst_hi", hi_out, 32'd0);
    chk("post_rst_lo", lo_out, 32'd0);
    chk("post_rst_no_ce", 32'(ce_count - ce0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- EX-stage initiator for the pipelined DIV unit.
- Accepts DIV/DIVU and MTHI/MTLO from the EX stage.
- Launches the divider with a one-cycle CE pulse, holds the pipeline through `stall_req`, captures quotient/remainder on the divider's CE return, and owns the architectural HI/LO registers.
- Drains in-flight results after a flush so stale results never reach HI/LO.

Parameters:
- DATA_W, 32, operand/HI/LO width
- DIV_LAT, 16, divider latency: cycles from `div_ce` high to `div_done` high
- TMO_SLACK, 4, extra cycles past DIV_LAT before a missing `div_done` is flagged

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  kill the EX instruction and any outstanding divide
- ex_stall  in  1  external pipeline hold; EX instruction is not retired while high
- ex_valid  in  1  EX slot holds a valid instruction
- ex_is_div  in  1  instruction is DIV or DIVU
- ex_signed  in  1  1=DIV, 0=DIVU
- ex_mthi  in  1  instruction is MTHI
- ex_mtlo  in  1  instruction is MTLO
- ex_rs  in  DATA_W  dividend / MTHI/MTLO source
- ex_rt  in  DATA_W  divisor
- div_ce  out  1  one-cycle launch pulse to divider
- div_signed  out  1  signedness to divider
- div_dividend  out  DATA_W  registered dividend
- div_divisor  out  DATA_W  registered divisor
- div_done  in  1  divider CE_out; result valid this cycle
- div_quotient  in  DATA_W  divider quotient
- div_remainder  in  DATA_W  divider remainder
- stall_req  out  1  hold IF/ID/EX
- hi_out  out  DATA_W  HI register
- lo_out  out  DATA_W  LO register
- div_err  out  1  sticky: `div_done` not seen by deadline

Behaviour:
- Reset (async, `reset`=0):
  - State IDLE; HI, LO, `div_dividend`, `div_divisor`, counter = 0.
  - `div_ce`, `div_signed`, `stall_req`, `div_err` = 0.
  - Reset mid-operation abandons everything; divider output is ignored until the next ISSUE.
- States: IDLE, ISSUE, WAIT, WRITE, DRAIN. `stall_req` is combinational from state and inputs.
- IDLE:
  - `ex_valid & ex_is_div & ex_rt!=0 & !flush`: `stall_req`=1, latch operands and signedness, go to ISSUE.
  - `ex_valid & ex_is_div & ex_rt==0`: no launch, no stall, HI/LO unchanged.
  - `ex_valid & ex_mthi & !flush & !ex_stall`: HI <= `ex_rs` at the edge.
  - `ex_valid & ex_mtlo & !flush & !ex_stall`: LO <= `ex_rs` at the edge.
- ISSUE (cycle 1):
  - `div_ce`=1 for exactly this cycle; `stall_req`=1.
  - Counter <= 0; go to WAIT.
- WAIT:
  - `stall_req`=1; counter increments each cycle.
  - On `div_done`: capture LO <= `div_quotient`, HI <= `div_remainder`; go to WRITE.
  - With DIV_LAT=16, `div_done` arrives in cycle 17 and WRITE is cycle 18.
  - If counter reaches DIV_LAT+TMO_SLACK without `div_done`: set `div_err` (sticky until reset), go to IDLE, HI/LO unchanged.
- WRITE:
  - `stall_req`=0 so the DIV retires.
  - If `ex_stall`=1, remain in WRITE; the same DIV must not relaunch.
  - Go to IDLE when `ex_stall`=0.
- Flush:
  - In ISSUE or WAIT: go to DRAIN; HI/LO never written by that divide.
  - In WRITE: capture already committed; go to IDLE.
  - In IDLE: nothing launched or written.
  - Flush in the same cycle as `div_done` in WAIT: result discarded, go to IDLE.
- DRAIN:
  - `stall_req`=0 unless `ex_valid & (ex_is_div|ex_mthi|ex_mtlo)`, in which case `stall_req`=1.
  - Exit to IDLE on `div_done` (discarded) or at the timeout deadline (no `div_err`).
  - If the flush occurred in ISSUE, `div_ce` was still issued; DRAIN waits for its done.
- In ISSUE/WAIT/DRAIN, MTHI/MTLO are held via `stall_req` and applied after the return to IDLE.
- Only one divide is ever outstanding.
- `hi_out`/`lo_out` update only at the clock edge listed above.

Decomposition:
- Shared header (alongside cpu.h/isa.h):
  - state encodings DIV_ST_IDLE..DIV_ST_DRAIN (3 bits)
  - DATA_W default
  - DIV_LAT default, matching the DIV pipeline depth
- Sub-module `hilo_reg`: HI/LO storage with prioritised write ports (divide capture vs. MTHI/MTLO).
- FSM and counter stay in `div_issue_ctrl`.

Test Plan:
- DIVU 100/7, divider model with DIV_LAT=16 -> `div_ce` pulse in cycle 1; `stall_req` high cycles 0..17, low in cycle 18; LO=14, HI=2.
- DIV -7/2 signed -> `div_signed`=1; LO=0xFFFFFFFD, HI=0xFFFFFFFF; a second DIV 8/2 back-to-back -> LO=4, HI=0, exactly one `div_ce` per instruction.
- DIV 5/0 with HI=LO=0x1234 -> no `div_ce`, `stall_req` stays 0, HI/LO unchanged.
- Flush in WAIT cycle 5 -> DRAIN, `div_done` at cycle 17 discarded, HI/LO unchanged; a new DIVU 9/3 presented in cycle 10 stalls until drain ends, then completes with LO=3, HI=0.
- MTHI 0xAAAA0000 in IDLE -> HI updated next edge; MTLO presented during WAIT -> held by `stall_req`, written after the divide's WRITE, overriding its LO.
- Divider model never asserts `div_done` -> `div_err`=1 at WAIT counter 20, state IDLE; assert `reset`=0 mid-WAIT on a later divide -> all outputs 0 immediately.
